// File: rtl/gf163_d32_mul_ctrl.sv
// rtl/gf163_d32_mul_ctrl.sv - sequencing controller for the GF(2^163) D=32 digit-serial multiplier
// Latches operands, clears the accumulator, streams B MSD-first, waits out the pipeline, captures C.
module gf163_d32_mul_ctrl #(
  parameter int M        = 163,
  parameter int D        = 32,
  parameter int NDIG     = 6,
  parameter int PIPE_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] a_in,
  input  logic [M-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] c_out,
  output logic         dp_clr,
  output logic         dp_en,
  output logic [M-1:0] dp_a,
  output logic [D-1:0] dp_digit,
  output logic         dp_last,
  input  logic [M-1:0] dp_c
);

  localparam int W  = NDIG * D;
  localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int LW = 4;

  typedef enum logic [1:0] {IDLE, LOAD, FEED, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [LW-1:0]  lat_q, lat_d;
  logic [M-1:0]   a_reg_q, a_reg_d;
  logic [W-1:0]   b_pad_q, b_pad_d;
  logic [M-1:0]   c_q, c_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           clr_q, clr_d;
  logic           en_q, en_d;
  logic           last_q, last_d;
  logic [D-1:0]   digit_q, digit_d;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    lat_d   = lat_q;
    a_reg_d = a_reg_q;
    b_pad_d = b_pad_q;
    c_d     = c_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          a_reg_d = a_in;
          b_pad_d = {{(W-M){1'b0}}, b_in};
          k_d     = KW'(NDIG - 1);
        end
      end
      LOAD: state_d = FEED;
      FEED: begin
        if (k_q == '0) begin
          state_d = DRAIN;
          lat_d   = LW'(PIPE_LAT - 1);
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      DRAIN: begin
        if (lat_q == '0) begin
          state_d = IDLE;
          c_d     = dp_c;
          done_d  = 1'b1;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered: derive them from the state being entered.
    busy_d  = (state_d != IDLE);
    clr_d   = (state_d == LOAD);
    en_d    = (state_d == FEED);
    last_d  = en_d && (k_d == '0);
    digit_d = en_d ? b_pad_d[D*int'(k_d) +: D] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      lat_q   <= '0;
      a_reg_q <= '0;
      b_pad_q <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      last_q  <= 1'b0;
      digit_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      lat_q   <= lat_d;
      a_reg_q <= a_reg_d;
      b_pad_q <= b_pad_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
      en_q    <= en_d;
      last_q  <= last_d;
      digit_q <= digit_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign c_out    = c_q;
  assign dp_clr   = clr_q;
  assign dp_en    = en_q;
  assign dp_a     = a_reg_q;
  assign dp_digit = digit_q;
  assign dp_last  = last_q;

endmodule

// File: tb/tb_gf163_d32_mul_ctrl.sv
// tb/tb_gf163_d32_mul_ctrl.sv - self-checking bench for gf163_d32_mul_ctrl
// Bench plays the datapath (digit reassembly + GF multiply + delay) and checks against a timeline model.
module tb_gf163_d32_mul_ctrl;

  localparam int PL = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [162:0] a_in, b_in;
  logic         busy, done, dp_clr, dp_en, dp_last;
  logic [162:0] c_out, dp_a, dp_c;
  logic [31:0]  dp_digit;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gf163_d32_mul_ctrl #(.M(163), .D(32), .NDIG(6), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .c_out(c_out), .dp_clr(dp_clr), .dp_en(dp_en),
    .dp_a(dp_a), .dp_digit(dp_digit), .dp_last(dp_last), .dp_c(dp_c)
  );

  function automatic logic [162:0] gf_mul(input logic [162:0] a, input logic [162:0] b);
    logic [162:0] r, x;
    r = '0;
    x = a;
    for (int i = 0; i < 163; i++) begin
      if (b[i]) r = r ^ x;
      x = x[162] ? ((x << 1) ^ 163'hC9) : (x << 1);
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Datapath stand-in: rebuild B from the digit stream, multiply, delay PL stages.
  logic [191:0] acc;
  logic [162:0] p1, p2;
  always @(posedge clk) begin : dp_stub
    logic [191:0] nxt;
    logic [191:0] junk;
    nxt  = {acc[159:0], dp_digit};
    junk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    if (dp_clr) acc <= '0;
    else if (dp_en) acc <= nxt;
    p1 <= (dp_en && dp_last) ? gf_mul(dp_a, nxt[162:0]) : junk[162:0];
    p2 <= p1;
  end
  assign dp_c = p2;

  // Timeline model: ph = cycles since the accepting edge, -1 when idle.
  int           ph = -1;
  logic [162:0] a_m = '0, b_m = '0, c_m = '0;
  always @(posedge clk) begin
    if (rst) begin
      ph = -1; a_m = '0; b_m = '0; c_m = '0;
    end else if (ph < 0 || ph == 8 + PL) begin
      if (start) begin
        ph = 1; a_m = a_in; b_m = b_in;
      end else begin
        ph = -1;
      end
    end else begin
      ph++;
      if (ph == 8 + PL) c_m = gf_mul(a_m, b_m);
    end
  end

  always @(negedge clk) begin : compare
    logic [191:0] bp;
    logic         en_m;
    bp   = {29'b0, b_m};
    en_m = (ph >= 2 && ph <= 7);
    chk("busy",     busy,    ph >= 1 && ph <= 7 + PL);
    chk("done",     done,    ph == 8 + PL);
    chk("dp_clr",   dp_clr,  ph == 1);
    chk("dp_en",    dp_en,   en_m);
    chk("dp_last",  dp_last, ph == 7);
    chk("dp_digit", dp_digit, en_m ? bp[32*(7-ph) +: 32] : 32'h0);
    chk("dp_a",     dp_a,    a_m);
    chk("c_out",    c_out,   c_m);
  end

  task automatic run_op(input logic [162:0] a, input logic [162:0] b,
                        input logic [191:0] dig, input logic [162:0] c);
    start = 1'b1; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0;
    chk("op_clr", dp_clr, 1'b1);
    chk("op_busy", busy, 1'b1);
    for (int i = 5; i >= 0; i--) begin
      @(negedge clk);
      chk("op_digit", dp_digit, dig[32*i +: 32]);
      chk("op_last", dp_last, i == 0);
    end
    repeat (PL + 1) @(negedge clk);
    chk("op_done", done, 1'b1);
    chk("op_busy_done", busy, 1'b0);
    chk("op_c", c_out, c);
  endtask

  initial begin
    logic [191:0] r;
    int           ndone;
    rst = 1'b1; start = 1'b1; a_in = 163'd1; b_in = 163'd1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_clr", dp_clr, 1'b0);
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_c", c_out, 163'd0);

    run_op(163'd1, 163'd1, 192'h1, 163'd1);
    run_op(163'd1, {163{1'b1}},
           192'h7_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, {163{1'b1}});
    run_op(163'd1 << 162, 163'd2, 192'h2, 163'hC9);

    // Starts during busy with new operands are ignored.
    start = 1'b1; a_in = 163'd3; b_in = 163'd5;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      start = (cyc == 3 || cyc == 6);
      if (start) begin a_in = 163'd7; b_in = 163'd7; end
      if (cyc == 10) begin
        chk("ign_done", done, 1'b1);
        chk("ign_c", c_out, 163'hF);
      end
      if (cyc == 11) chk("ign_single_done", done, 1'b0);
    end
    start = 1'b0;

    // Reset in the middle of FEED abandons the operation.
    start = 1'b1; a_in = 163'd9; b_in = 163'd9;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_en", dp_en, 1'b0);
    chk("mid_rst_a", dp_a, 163'd0);
    ndone = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("mid_rst_no_done", ndone, 0);
    run_op(163'd3, 163'd5, 192'h5, 163'hF);

    // Back-to-back with start held high and operands changing every cycle.
    start = 1'b1;
    ndone = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      a_in = r[162:0];
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      b_in = r[162:0];
      if (done) ndone++;
      chk("b2b_done", done, (cyc % 10) == 0);
    end
    chk("b2b_count", ndone, 3);
    start = 1'b0;
    repeat (15) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
